// File: rtl/div_result_stage.sv
// rtl/div_result_stage.sv - registered result stage with divide-by-zero screening, FIFO and event counters
module div_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       div_q,
    input  logic             carry_in,
    input  logic [7:0]       divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_q,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_dbz,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] result_count,
    output logic [CNT_W-1:0] dbz_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_ONE   = (AW+1)'(1);

    // Entry layout: {q[7:0], cout, zero, dbz}
    logic [10:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic [10:0]      r_head;
    logic [CNT_W-1:0] r_res_cnt;
    logic [CNT_W-1:0] r_dbz_cnt;

    logic             w_dbz;
    logic [7:0]       w_q;
    logic             w_zero;
    logic [10:0]      w_in_entry;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_nxt;
    logic             w_load;
    logic [10:0]      w_next_head;

    // Substitute 0xFF before storing so an undefined quotient never enters the FIFO.
    assign w_dbz      = (divisor == 8'h00);
    assign w_q        = w_dbz ? 8'hFF : div_q;
    assign w_zero     = (w_q == 8'h00);
    assign w_in_entry = {w_q, carry_in, w_zero, w_dbz};

    assign in_ready  = (r_occ != L_DEPTH);
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_rd_nxt  = r_rd_ptr + AW'(1);

    assign {out_q, out_cout, out_zero, out_dbz} = r_head;
    assign result_count = r_res_cnt;
    assign dbz_count    = r_dbz_cnt;

    // The head register mirrors the oldest entry and keeps its value when the FIFO drains.
    always_comb begin
        w_load      = 1'b0;
        w_next_head = w_in_entry;
        if (w_pop && (r_occ > L_ONE)) begin
            w_load      = 1'b1;
            w_next_head = r_mem[w_rd_nxt];
        end else if (w_push && ((r_occ == '0) || w_pop)) begin
            w_load      = 1'b1;
            w_next_head = w_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + L_ONE;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - L_ONE;
            end
            if (w_load) begin
                r_head <= w_next_head;
            end
        end
    end

    // Clear wins over a same-cycle increment; that event is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_cnt <= '0;
            r_dbz_cnt <= '0;
        end else if (clear_cnt) begin
            r_res_cnt <= '0;
            r_dbz_cnt <= '0;
        end else begin
            if (w_pop && (r_res_cnt != '1)) begin
                r_res_cnt <= r_res_cnt + CNT_W'(1);
            end
            if (w_push && w_dbz && (r_dbz_cnt != '1)) begin
                r_dbz_cnt <= r_dbz_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_result_stage.sv
// tb/tb_div_result_stage.sv - randomized and directed check of div_result_stage against a queue model
module tb_div_result_stage;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] div_q;
    logic       carry_in;
    logic [7:0] divisor;
    logic       out_ready;
    logic       clear_cnt;

    logic       in_ready, out_valid, out_cout, out_zero, out_dbz;
    logic [7:0] out_q, result_count, dbz_count;
    logic       in_ready2, out_valid2, out_cout2, out_zero2, out_dbz2;
    logic [7:0] out_q2;
    logic [1:0] result_count2, dbz_count2;

    typedef struct {
        logic [7:0] q;
        logic       c;
        logic       z;
        logic       d;
    } ent_t;

    ent_t mq[$];
    int   raw_res;
    int   raw_dbz;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    div_result_stage #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .div_q(div_q), .carry_in(carry_in), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
        .out_cout(out_cout), .out_zero(out_zero), .out_dbz(out_dbz),
        .clear_cnt(clear_cnt), .result_count(result_count), .dbz_count(dbz_count)
    );

    div_result_stage #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .div_q(div_q), .carry_in(carry_in), .divisor(divisor),
        .out_valid(out_valid2), .out_ready(out_ready), .out_q(out_q2),
        .out_cout(out_cout2), .out_zero(out_zero2), .out_dbz(out_dbz2),
        .clear_cnt(clear_cnt), .result_count(result_count2), .dbz_count(dbz_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One clock: drive, compare against the model, advance the model at the edge.
    task automatic cycle(input logic iv, input logic [7:0] q, input logic c,
                         input logic [7:0] d, input logic ordy, input logic clr);
        ent_t e;
        bit   do_push;
        bit   do_pop;
        in_valid  = iv;
        div_q     = q;
        carry_in  = c;
        divisor   = d;
        out_ready = ordy;
        clear_cnt = clr;
        #1;
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready2", in_ready2, mq.size() < DEPTH);
        chk("out_valid2", out_valid2, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_q", out_q, mq[0].q);
            chk("out_cout", out_cout, mq[0].c);
            chk("out_zero", out_zero, mq[0].z);
            chk("out_dbz", out_dbz, mq[0].d);
            chk("out2", {out_q2, out_cout2, out_zero2, out_dbz2},
                {mq[0].q, mq[0].c, mq[0].z, mq[0].d});
        end
        chk("result_count", result_count, sat(raw_res, 8));
        chk("dbz_count", dbz_count, sat(raw_dbz, 8));
        chk("result_count2", result_count2, sat(raw_res, 2));
        chk("dbz_count2", dbz_count2, sat(raw_dbz, 2));
        do_pop  = (mq.size() != 0) && ordy;
        do_push = iv && (mq.size() < DEPTH);
        e.d = (d == 8'd0);
        e.q = e.d ? 8'hFF : q;
        e.c = c;
        e.z = (e.q == 8'd0);
        @(posedge clk);
        if (do_pop) begin
            void'(mq.pop_front());
            raw_res++;
        end
        if (do_push) begin
            mq.push_back(e);
            if (e.d) raw_dbz++;
        end
        if (clr) begin
            raw_res = 0;
            raw_dbz = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 8'h01, ordy, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; raw_res = 0; raw_dbz = 0;
        rst_n = 1'b0; in_valid = 1'b0; div_q = '0; carry_in = 1'b0;
        divisor = 8'h01; out_ready = 1'b0; clear_cnt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outs", {out_q, out_cout, out_zero, out_dbz}, 0);
        chk("rst_counts", {result_count, dbz_count}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic push, carry pass-through, divide-by-zero, zero quotient
        cycle(1'b1, 8'd6, 1'b0, 8'd3, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("basic_result_count", result_count, 1);
        cycle(1'b1, 8'd2, 1'b1, 8'd100, 1'b1, 1'b0);
        idle(1, 1'b1);
        cycle(1'b1, 8'($urandom), 1'b0, 8'd0, 1'b1, 1'b0);
        chk("dbz_head_q", out_q, 8'hFF);
        idle(1, 1'b1);
        chk("dbz_count_one", dbz_count, 1);
        cycle(1'b1, 8'd0, 1'b0, 8'd5, 1'b1, 1'b0);
        idle(1, 1'b1);

        // Backpressure: third push refused, then drain in order
        cycle(1'b1, 8'd1, 1'b0, 8'd7, 1'b0, 1'b0);
        cycle(1'b1, 8'd2, 1'b0, 8'd7, 1'b0, 1'b0);
        cycle(1'b1, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);
        idle(2, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(3 + i), 1'(i), 8'd9, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Saturation of the narrow counters, then clear colliding with a dbz push
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'd4, 1'b0, 8'd0, 1'b1, 1'b0);
        chk("dbz_sat2", dbz_count2, 3);
        cycle(1'b1, 8'd4, 1'b0, 8'd0, 1'b1, 1'b1);
        chk("dbz_clear", dbz_count2, 0);
        idle(2, 1'b1);

        // Reset in the middle of operation with two entries held
        cycle(1'b1, 8'd11, 1'b0, 8'd1, 1'b0, 1'b0);
        cycle(1'b1, 8'd12, 1'b0, 8'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_counts", {result_count, dbz_count}, 0);
        #9 rst_n = 1'b1;
        mq.delete();
        raw_res = 0;
        raw_dbz = 0;
        @(negedge clk);
        idle(3, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), 1'($urandom),
                  (($urandom % 4) == 0) ? 8'd0 : 8'($urandom),
                  1'($urandom), ($urandom % 40) == 0);
        end
        idle(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_result_stage.md
Name: div_result_stage

Overview:
Registered result stage directly downstream of the combinational 8-bit division unit in the ALU.
- Captures quotient, carry-out flag and divisor each time a valid/ready handshake completes.
- Screens for divide-by-zero, derives zero and DBZ status flags, and buffers results in a small FIFO.
- Presents results to the writeback/consumer side through a valid/ready interface.
- Keeps saturating counters of completed results and divide-by-zero events.

Parameters:
DEPTH, 2, FIFO entries; power of two, at least 2.
CNT_W, 8, width of the result and DBZ event counters.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  division result on div_q/carry_in/divisor is valid.
in_ready  output  1  stage can accept a result; equals !full.
div_q  input  8  quotient from the division unit.
carry_in  input  1  carry-out flag from the division unit.
divisor  input  8  B operand associated with div_q; used for divide-by-zero detection.
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer accepts the head entry.
out_q  output  8  quotient after divide-by-zero substitution.
out_cout  output  1  carry flag of the head entry.
out_zero  output  1  high when out_q == 8'h00.
out_dbz  output  1  high when the head entry had divisor == 0.
clear_cnt  input  1  synchronous clear of both counters.
result_count  output  CNT_W  saturating count of pops.
dbz_count  output  CNT_W  saturating count of pushes with divisor == 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - write pointer, read pointer and occupancy clear to 0.
  - out_valid=0, in_ready=1.
  - out_q=0, out_cout=0, out_zero=0, out_dbz=0.
  - both counters = 0.
  - FIFO storage contents are don't-care.
- Push: in_valid && in_ready.
  - Stored entry: {q, cout, zero, dbz}.
  - dbz = (divisor == 0).
  - q = dbz ? 8'hFF : div_q. An undefined or X div_q is never stored when dbz=1.
  - cout = carry_in, passed through unchanged, including when dbz=1.
  - zero = (q == 0), computed on the substituted value, so zero=0 whenever dbz=1.
- Pop: out_valid && out_ready; advances the read pointer.
- Outputs:
  - out_* are driven from the head entry; out_valid = (occupancy != 0).
  - When out_valid=0, out_q/out_cout/out_zero/out_dbz hold their last values and must not be sampled.
- Latency: a push in cycle N makes out_valid high in cycle N+1 if the FIFO was empty. There is no combinational in→out bypass.
- Full: in_ready=0; in_valid is ignored and div_q is not sampled. in_ready is registered from occupancy, so there is no push-on-pop-when-full.
- Simultaneous push and pop (not full, not empty): occupancy unchanged; both pointers advance.
- Empty with push: occupancy becomes 1; no pop can occur in the same cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits, ranging 0..DEPTH.
- Ordering: strict FIFO; entries are never dropped or duplicated.
- Counters:
  - result_count increments on each pop; dbz_count increments on each push with dbz=1.
  - Both saturate at 2^CNT_W-1.
  - clear_cnt has priority over an increment in the same cycle: that cycle's event is lost and the counter reads 0.
- Reset mid-operation: all entries are discarded immediately. out_valid falls asynchronously with rst_n; no entry is presented after reset is released.
- Upstream contract: div_q/carry_in/divisor must be stable while in_valid=1 && in_ready=0. This stage does not check it.

Test Plan:
- Basic push: div_q=6 (20/3), divisor=3, carry_in=0, out_ready=1 → next cycle out_valid=1, out_q=6, out_zero=0, out_dbz=0; result_count=1 after the pop.
- Carry pass-through: div_q=2, carry_in=1 (200+100 overflow), divisor=100 → out_q=2, out_cout=1.
- Divide-by-zero: divisor=0, div_q=X, carry_in=0 → out_q=8'hFF, out_dbz=1, out_zero=0; dbz_count=1. Separately, div_q=0 with divisor=5 → out_zero=1.
- Backpressure/full: out_ready=0, three pushes of q=1,2,3 → in_ready=0 after the second push and q=3 is refused. Then out_ready=1 → pops in order 1,2 and in_ready returns to 1. Push 3 again; simultaneous push/pop over ten back-to-back cycles → no loss across pointer wrap.
- Reset mid-operation: two entries held, rst_n low for one cycle mid-cycle → out_valid=0 asynchronously, in_ready=1, counters=0; after release out_valid stays 0 until a new push.
- Counter saturation and clear: CNT_W=2, five dbz pushes → dbz_count=3. clear_cnt together with a dbz push → dbz_count=0.
